// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge: FSM state encoding,
// APB data width and the default slave address window.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10,
      DERR   = 2'b11
   } apb_state_e;

   localparam int APB_DW      = 32;
   localparam int DEF_SEL_LSB = 12;
   localparam int DEF_SEL_W   = 4;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational slave decode: the select field of the address picks one slave;
// indices at or beyond NUM_SLAVES are flagged invalid and select nobody.
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int SEL_LSB    = DEF_SEL_LSB,
   parameter int SEL_W      = DEF_SEL_W
) (
   input  logic [APB_DW-1:0]     addr_i,
   output logic [SEL_W-1:0]      idx_o,
   output logic [NUM_SLAVES-1:0] sel_o,
   output logic                  valid_o
);

   always_comb begin
      idx_o   = addr_i[SEL_LSB+SEL_W-1:SEL_LSB];
      valid_o = (32'(idx_o) < NUM_SLAVES);
      sel_o   = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         sel_o[i] = valid_o && (idx_o == SEL_W'(i));
      end
   end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 master bridge: turns a core peripheral request into a SETUP/ACCESS
// transfer, with decode-error and wait-state timeout completions.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int SEL_LSB    = DEF_SEL_LSB,
   parameter int SEL_W      = DEF_SEL_W,
   parameter int TIMEOUT    = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         transEn,
   input  logic                         proc_write,
   input  logic [APB_DW-1:0]            proc_addr,
   input  logic [APB_DW-1:0]            proc_wdata,
   output logic [APB_DW-1:0]            proc_rdata,
   output logic                         proc_ready,
   output logic                         bus_err,
   output logic [APB_DW-1:0]            PADDR,
   output logic [NUM_SLAVES-1:0]        PSEL,
   output logic                         PENABLE,
   output logic                         PWRITE,
   output logic [APB_DW-1:0]            PWDATA,
   input  logic [APB_DW*NUM_SLAVES-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]        PREADY,
   input  logic [NUM_SLAVES-1:0]        PSLVERR
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   apb_state_e              state_q, state_d;
   logic [APB_DW-1:0]       paddr_q, paddr_d;
   logic [APB_DW-1:0]       pwdata_q, pwdata_d;
   logic                    pwrite_q, pwrite_d;
   logic [NUM_SLAVES-1:0]   psel_q, psel_d;
   logic                    penable_q, penable_d;
   logic [SEL_W-1:0]        sel_idx_q, sel_idx_d;
   logic [7:0]              wait_cnt_q, wait_cnt_d;

   logic [SEL_W-1:0]        dec_idx;
   logic [NUM_SLAVES-1:0]   dec_sel;
   logic                    dec_valid;
   logic                    sel_ready;
   logic                    sel_err;
   logic [APB_DW-1:0]       sel_rdata;

   apb_addr_decoder #(
      .NUM_SLAVES (NUM_SLAVES),
      .SEL_LSB    (SEL_LSB),
      .SEL_W      (SEL_W)
   ) u_dec (
      .addr_i  (proc_addr),
      .idx_o   (dec_idx),
      .sel_o   (dec_sel),
      .valid_o (dec_valid)
   );

   // Only the captured slave's response is looked at; all others are ignored.
   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_idx_q == SEL_W'(i)) begin
            sel_ready = PREADY[i];
            sel_err   = PSLVERR[i];
            sel_rdata = PRDATA[APB_DW*i +: APB_DW];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      paddr_d    = paddr_q;
      pwdata_d   = pwdata_q;
      pwrite_d   = pwrite_q;
      psel_d     = psel_q;
      penable_d  = penable_q;
      sel_idx_d  = sel_idx_q;
      wait_cnt_d = wait_cnt_q;
      proc_ready = 1'b0;
      bus_err    = 1'b0;
      proc_rdata = '0;
      unique case (state_q)
         IDLE: begin
            if (transEn) begin
               if (dec_valid) begin
                  paddr_d   = proc_addr;
                  pwdata_d  = proc_wdata;
                  pwrite_d  = proc_write;
                  sel_idx_d = dec_idx;
                  psel_d    = dec_sel;
                  state_d   = SETUP;
               end else begin
                  state_d = DERR;
               end
            end
         end
         SETUP: begin
            penable_d  = 1'b1;
            wait_cnt_d = '0;
            state_d    = ACCESS;
         end
         ACCESS: begin
            if (sel_ready) begin
               proc_ready = 1'b1;
               bus_err    = sel_err;
               proc_rdata = pwrite_q ? '0 : sel_rdata;
               psel_d     = '0;
               penable_d  = 1'b0;
               state_d    = IDLE;
            end else if (wait_cnt_q == TIMEOUT_C) begin
               proc_ready = 1'b1;
               bus_err    = 1'b1;
               psel_d     = '0;
               penable_d  = 1'b0;
               state_d    = IDLE;
            end else if (wait_cnt_q != 8'hFF) begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         DERR: begin
            proc_ready = 1'b1;
            bus_err    = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         paddr_q    <= '0;
         pwdata_q   <= '0;
         pwrite_q   <= 1'b0;
         psel_q     <= '0;
         penable_q  <= 1'b0;
         sel_idx_q  <= '0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         paddr_q    <= paddr_d;
         pwdata_q   <= pwdata_d;
         pwrite_q   <= pwrite_d;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         sel_idx_q  <= sel_idx_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign PADDR   = paddr_q;
   assign PWDATA  = pwdata_q;
   assign PWRITE  = pwrite_q;
   assign PSEL    = psel_q;
   assign PENABLE = penable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed plus randomised bench for apb_master_bridge with a wait-state slave
// responder and a queue of expected {bus_err, proc_rdata} completions.
module tb_apb_master_bridge;

   localparam int NS      = 4;
   localparam int TIMEOUT = 255;

   logic          clk;
   logic          rst;
   logic          transEn;
   logic          proc_write;
   logic [31:0]   proc_addr;
   logic [31:0]   proc_wdata;
   logic [31:0]   proc_rdata;
   logic          proc_ready;
   logic          bus_err;
   logic [31:0]   PADDR;
   logic [NS-1:0] PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [31:0]   PWDATA;
   logic [32*NS-1:0] PRDATA;
   logic [NS-1:0] PREADY;
   logic [NS-1:0] PSLVERR;

   int vectors = 0;
   int errors  = 0;
   int wait_cfg [NS];
   logic err_cfg [NS];
   int acc_cnt;
   logic [32:0] exp_q [$];

   apb_master_bridge #(.NUM_SLAVES(NS), .SEL_LSB(12), .SEL_W(4), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .transEn    (transEn),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_rdata (proc_rdata),
      .proc_ready (proc_ready),
      .bus_err    (bus_err),
      .PADDR      (PADDR),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PWRITE     (PWRITE),
      .PWDATA     (PWDATA),
      .PRDATA     (PRDATA),
      .PREADY     (PREADY),
      .PSLVERR    (PSLVERR)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // slave responder: selected slave waits wait_cfg ACCESS cycles; unselected
   // slaves drive ready/error high so a wrong response mux shows up
   always @(posedge clk) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

   always_comb begin
      PRDATA  = '0;
      PREADY  = '0;
      PSLVERR = '0;
      for (int i = 0; i < NS; i++) begin
         PRDATA[32*i +: 32] = 32'hCAFE_0000 | 32'(i);
         if (PSEL[i]) begin
            PREADY[i]  = PENABLE && (acc_cnt >= wait_cfg[i]);
            PSLVERR[i] = err_cfg[i];
         end else begin
            PREADY[i]  = 1'b1;
            PSLVERR[i] = 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble();
      proc_write = 1'($urandom_range(0, 1));
      proc_addr  = $urandom();
      proc_wdata = $urandom();
   endtask

   // driver: issue one request in the current IDLE cycle and follow it to completion
   task automatic run_xfer(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [NS-1:0] exp_psel,
                           input logic exp_err, input logic [31:0] exp_rdata,
                           input int exp_lat, input bit keep_en);
      int cyc;
      bit done;
      logic [32:0] exp_v;
      transEn    = 1'b1;
      proc_write = wr;
      proc_addr  = addr;
      proc_wdata = wdata;
      exp_q.push_back({exp_err, exp_rdata});
      cyc  = 0;
      done = 0;
      while (!done) begin
         @(negedge clk);
         chk({tag, ":onehot"}, 64'($countones(PSEL) <= 1), 64'd1);
         if (cyc == 0) begin
            chk({tag, ":idle_psel"}, 64'(PSEL), 64'd0);
            chk({tag, ":idle_penable"}, 64'(PENABLE), 64'd0);
         end else if (exp_psel != '0) begin
            chk({tag, ":psel"}, 64'(PSEL), 64'(exp_psel));
            chk({tag, ":penable"}, 64'(PENABLE), 64'(cyc >= 2));
            chk({tag, ":paddr"}, 64'(PADDR), 64'(addr));
            chk({tag, ":pwdata"}, 64'(PWDATA), 64'(wdata));
            chk({tag, ":pwrite"}, 64'(PWRITE), 64'(wr));
         end else begin
            chk({tag, ":derr_psel"}, 64'(PSEL), 64'd0);
         end
         if (proc_ready) begin
            done = 1;
         end else begin
            chk({tag, ":quiet_rdata"}, 64'(proc_rdata), 64'd0);
            chk({tag, ":quiet_err"}, 64'(bus_err), 64'd0);
            if (cyc >= exp_lat + 20) begin
               chk({tag, ":budget"}, 64'(cyc), 64'(exp_lat));
               done = 1;
            end else begin
               next_cycle();
               cyc++;
               scramble();
               transEn = keep_en;
            end
         end
      end
      chk({tag, ":latency"}, 64'(cyc), 64'(exp_lat));
      // scoreboard
      if (exp_q.size() == 0) begin
         chk({tag, ":sb_empty"}, 64'd1, 64'd0);
      end else begin
         exp_v = exp_q.pop_front();
         chk({tag, ":err"}, 64'(bus_err), 64'(exp_v[32]));
         chk({tag, ":rdata"}, 64'(proc_rdata), 64'(exp_v[31:0]));
      end
   endtask

   task automatic idle_gap(input string tag);
      next_cycle();
      transEn = 1'b0;
      @(negedge clk);
      chk({tag, ":gap_psel"}, 64'(PSEL), 64'd0);
      chk({tag, ":gap_penable"}, 64'(PENABLE), 64'd0);
      chk({tag, ":gap_ready"}, 64'(proc_ready), 64'd0);
      chk({tag, ":gap_rdata"}, 64'(proc_rdata), 64'd0);
      next_cycle();
   endtask

   initial begin
      int idx, w;
      logic wr, e;
      logic [31:0] addr;
      logic [NS-1:0] psel_e;
      rst = 1'b1;
      transEn = 1'b0;
      proc_write = 1'b0;
      proc_addr = '0;
      proc_wdata = '0;
      for (int i = 0; i < NS; i++) begin
         wait_cfg[i] = 0;
         err_cfg[i]  = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_psel", 64'(PSEL), 64'd0);
      chk("reset_penable", 64'(PENABLE), 64'd0);
      chk("reset_paddr", 64'(PADDR), 64'd0);
      chk("reset_pwdata", 64'(PWDATA), 64'd0);
      chk("reset_pwrite", 64'(PWRITE), 64'd0);
      chk("reset_ready", 64'({proc_ready, bus_err}), 64'd0);
      chk("reset_rdata", 64'(proc_rdata), 64'd0);
      rst = 1'b0;
      next_cycle();

      run_xfer("zw_read", 1'b0, 32'h0000_1004, 32'h0, 4'b0010, 1'b0, 32'hCAFE_0001, 2, 1'b0);
      idle_gap("zw_read");

      wait_cfg[2] = 3;
      run_xfer("ws_write", 1'b1, 32'h0000_2010, 32'h1234_5678, 4'b0100, 1'b0, 32'h0, 5, 1'b0);
      wait_cfg[2] = 0;
      idle_gap("ws_write");

      err_cfg[0] = 1'b1;
      run_xfer("slverr", 1'b0, 32'h0000_0008, 32'h0, 4'b0001, 1'b1, 32'hCAFE_0000, 2, 1'b0);
      err_cfg[0] = 1'b0;
      idle_gap("slverr");

      run_xfer("decode_err", 1'b0, 32'h0000_5000, 32'h0, 4'b0000, 1'b1, 32'h0, 1, 1'b0);
      idle_gap("decode_err");

      wait_cfg[3] = 100000;
      run_xfer("timeout", 1'b0, 32'h0000_3000, 32'h0, 4'b1000, 1'b1, 32'h0, 2 + TIMEOUT, 1'b0);
      idle_gap("timeout");

      // asynchronous reset while waiting in ACCESS
      transEn = 1'b1;
      proc_write = 1'b0;
      proc_addr = 32'h0000_3004;
      next_cycle();
      transEn = 1'b0;
      next_cycle();
      @(negedge clk);
      chk("rst_mid:penable_before", 64'(PENABLE), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid:psel", 64'(PSEL), 64'd0);
      chk("rst_mid:penable", 64'(PENABLE), 64'd0);
      chk("rst_mid:ready", 64'(proc_ready), 64'd0);
      chk("rst_mid:paddr", 64'(PADDR), 64'd0);
      wait_cfg[3] = 0;
      next_cycle();
      rst = 1'b0;
      run_xfer("post_rst", 1'b0, 32'h0000_3004, 32'h0, 4'b1000, 1'b0, 32'hCAFE_0003, 2, 1'b0);
      idle_gap("post_rst");

      // back-to-back with transEn held high: completions at cycles 2 and 5
      run_xfer("b2b_0", 1'b1, 32'h0000_0100, 32'hA5A5_0000, 4'b0001, 1'b0, 32'h0, 2, 1'b1);
      next_cycle();
      run_xfer("b2b_1", 1'b0, 32'h0000_1200, 32'h0, 4'b0010, 1'b0, 32'hCAFE_0001, 2, 1'b0);
      idle_gap("b2b");

      for (int n = 0; n < 8; n++) begin
         idx  = $urandom_range(0, 5);
         wr   = 1'($urandom_range(0, 1));
         w    = $urandom_range(0, 3);
         e    = 1'($urandom_range(0, 1));
         addr = (32'(idx) << 12) | (32'($urandom_range(0, 1023)) << 2);
         if (idx < NS) begin
            wait_cfg[idx] = w;
            err_cfg[idx]  = e;
            psel_e = 4'b0001 << idx;
            run_xfer("rand", wr, addr, $urandom(), psel_e, e,
                     wr ? 32'h0 : (32'hCAFE_0000 | 32'(idx)), 2 + w, 1'b0);
         end else begin
            run_xfer("rand_derr", wr, addr, $urandom(), 4'b0000, 1'b1, 32'h0, 1, 1'b0);
         end
         idle_gap("rand");
      end

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts the core's memory-stage peripheral requests (`transEn`, `proc_write`, `proc_addr`, `proc_wdata`) into APB3 transfers to up to NUM_SLAVES peripherals.
- Returns `proc_rdata`, `proc_ready` and `PENABLE` to the core. The core's hazard unit uses these to stall the pipeline until the transfer completes.
- Sits directly downstream of the core, between the core and the peripheral bus.

Parameters:
- NUM_SLAVES, 4, number of APB slaves; legal range 1..16.
- SEL_LSB, 12, lowest address bit of the slave-select field (4 KB window per slave).
- SEL_W, 4, width of the slave-select field `proc_addr[SEL_LSB+SEL_W-1:SEL_LSB]`.
- TIMEOUT, 255, maximum ACCESS-phase wait cycles before the bridge aborts the transfer.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- transEn  in  1  core requests a peripheral transfer
- proc_write  in  1  1 = write, 0 = read
- proc_addr  in  32  byte address
- proc_wdata  in  32  write data
- proc_rdata  out  32  read data returned to the core
- proc_ready  out  1  transfer complete, one-cycle pulse
- bus_err  out  1  error pulse, coincident with proc_ready
- PADDR  out  32  APB address
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE  out  1  APB access phase; also returned to the core
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PRDATA  in  32*NUM_SLAVES  slave read data, slave i at bits [32i+31:32i]
- PREADY  in  NUM_SLAVES  per-slave ready
- PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - state = IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, proc_rdata and the wait counter all clear to 0.
  - proc_ready = 0, bus_err = 0.
  - No partial transfer is resumed after reset.
- Decode: idx = `proc_addr[SEL_LSB+SEL_W-1:SEL_LSB]`; the address is valid when idx < NUM_SLAVES.
- IDLE:
  - transEn is sampled only in IDLE.
  - transEn=1 with a valid address: register PADDR, PWDATA, PWRITE and sel_idx; assert `PSEL[idx]`; next state SETUP.
  - transEn=1 with an invalid address: next state DERR; no PSEL is asserted.
- SETUP:
  - PSEL held, PENABLE = 0.
  - Unconditionally go to ACCESS; PENABLE = 1; wait counter = 0.
- ACCESS:
  - PSEL, PENABLE, PADDR, PWDATA and PWRITE are held stable.
  - If `PREADY[sel_idx]` = 1:
    - proc_ready = 1 combinationally in the same cycle.
    - proc_rdata = `PRDATA[sel_idx]` on a read, 0 on a write.
    - bus_err = `PSLVERR[sel_idx]`.
    - Next state IDLE; PSEL and PENABLE drop at the clock edge.
  - Else if the wait counter = TIMEOUT: proc_ready = 1, bus_err = 1, proc_rdata = 0; next state IDLE.
  - Else: increment the wait counter (8-bit, saturating, never wraps).
- DERR: one cycle with proc_ready = 1, bus_err = 1, proc_rdata = 0; next state IDLE.
- Latency:
  - Zero-wait-state slave: request sampled in IDLE at cycle 0; SETUP at cycle 1; ACCESS with proc_ready at cycle 2.
  - Minimum of one IDLE cycle between transfers, so back-to-back transfers issue every 3 cycles.
- Output rules:
  - proc_ready and bus_err are 0 in every cycle other than a completion cycle.
  - proc_rdata is 0 outside completion cycles.
- Ignored inputs:
  - PREADY and PSLVERR of non-selected slaves are ignored.
  - Changes on transEn, proc_addr, proc_wdata and proc_write outside IDLE are ignored.
- PSEL is at most one-hot in every cycle; PENABLE=1 implies exactly one PSEL bit set.

Decomposition:
- Shared package `apb_pkg` holds:
  - The state enum: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10, DERR=2'b11.
  - The APB data width constant (32).
  - The default slave window constants (SEL_LSB, SEL_W).
- Sub-module `apb_addr_decoder` (combinational): proc_addr → idx, one-hot sel vector and a valid flag.
- The FSM, capture registers and timeout counter stay in `apb_master_bridge`.

Test Plan:
- Zero-wait read: transEn=1, proc_write=0, addr=0x0000_1004, slave 1 PREADY=1, PRDATA=0xCAFE_0001 → PSEL=4'b0010 in SETUP and ACCESS; proc_ready pulses in cycle 2 with proc_rdata=0xCAFE_0001; bus_err=0.
- Wait-state write: addr=0x0000_2010, wdata=0x1234_5678, slave 2 PREADY low for 3 ACCESS cycles → PADDR, PWDATA and PWRITE=1 stable throughout; proc_ready pulses in cycle 5; proc_rdata=0.
- Slave error: slave 0 returns PREADY=1 with PSLVERR=1 on a read → proc_ready=1 and bus_err=1 in the same cycle; the FSM returns to IDLE.
- Decode error and timeout:
  - addr=0x0000_5000 (idx 5 ≥ 4) → no PSEL; one DERR cycle with proc_ready=1, bus_err=1.
  - Slave that never asserts PREADY → proc_ready=1, bus_err=1 exactly TIMEOUT+1 ACCESS cycles after ACCESS entry.
- Async reset in ACCESS → PSEL, PENABLE and proc_ready drop immediately; after release, a fresh transEn produces a normal 3-cycle transfer.
- Back-to-back: transEn held high with two different addresses → transfers complete on cycles 2 and 5; PSEL never has two bits set.
